sequence_stimulus_controller: RTL and testbench

Sequences a serial-input sequence detector FSM: latches a bit pattern and length, drives the pattern LSB-first onto the detector's `w`, and issues a one-cycle advance strobe per bit at a programmable rate. It samples the detector's `z` after every step, counts detections, and raises `done` when the pattern is exhausted. It sits between the board switches/keys and the detector instance, replacing manual stepping of `w`.

---
 rtl/sequence_stimulus_controller_if.sv | 24 ++
 rtl/sequence_stimulus_controller.sv | 95 +++++++++
 tb/tb_sequence_stimulus_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sequence_stimulus_controller_if.sv
// rtl/sequence_stimulus_controller_if.sv - control, pattern and detector signals of the stimulus controller
interface sequence_stimulus_controller_if;
  logic        start;
  logic        abort;
  logic [15:0] pattern;
  logic [4:0]  length;
  logic        z_in;
  logic        w_out;
  logic        step;
  logic [4:0]  bit_index;
  logic [4:0]  match_count;
  logic        busy;
  logic        done;

  modport master (
    output start, abort, pattern, length, z_in,
    input  w_out, step, bit_index, match_count, busy, done
  );

  modport slave (
    input  start, abort, pattern, length, z_in,
    output w_out, step, bit_index, match_count, busy, done
  );
endinterface

// File: rtl/sequence_stimulus_controller.sv
// rtl/sequence_stimulus_controller.sv - plays a latched bit pattern into a sequence detector and counts detections
module sequence_stimulus_controller #(
  parameter int STEP_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input logic                          clock,
  input logic                          resetnot,
  sequence_stimulus_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_CYCLES - 1);

  state_t           state, state_nx;
  logic [15:0]      pat_q;
  logic [4:0]       len_q;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       bit_index;
  logic [4:0]       match_count;
  logic             sample_q;
  logic             sample_last_q;

  logic accept, step_now, last_bit, final_sample;

  assign accept       = bus.start && !bus.abort && (state != RUN);
  assign step_now     = (state == RUN) && (cnt == LAST_CNT);
  assign last_bit     = (bit_index == len_q - 5'd1);
  // sample_last_q marks the pending sample belonging to the final step
  assign final_sample = (state == RUN) && sample_q && sample_last_q;

  always_ff @(posedge clock or negedge resetnot) begin
    if (!resetnot) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (bus.abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nx = RUN;
        RUN:     if (final_sample) state_nx = DONE;
        DONE:    if (bus.start) state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetnot) begin
    if (!resetnot) begin
      pat_q         <= '0;
      len_q         <= '0;
      cnt           <= '0;
      bit_index     <= '0;
      match_count   <= '0;
      sample_q      <= 1'b0;
      sample_last_q <= 1'b0;
    end else if (bus.abort) begin
      cnt           <= '0;
      sample_q      <= 1'b0;
      sample_last_q <= 1'b0;
    end else if (accept) begin
      pat_q         <= bus.pattern;
      len_q         <= (bus.length == 5'd0) ? 5'd16 : bus.length;
      cnt           <= '0;
      bit_index     <= '0;
      match_count   <= '0;
      sample_q      <= 1'b0;
      sample_last_q <= 1'b0;
    end else if (state == RUN) begin
      sample_q <= step_now;
      if (step_now) begin
        cnt           <= '0;
        sample_last_q <= last_bit;
        if (!last_bit) bit_index <= bit_index + 5'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (sample_q && bus.z_in && (match_count != 5'd16)) begin
        match_count <= match_count + 5'd1;
      end
    end
  end

  assign bus.w_out       = (state == RUN) ? pat_q[bit_index[3:0]] : 1'b0;
  assign bus.step        = step_now;
  assign bus.bit_index   = bit_index;
  assign bus.match_count = match_count;
  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_sequence_stimulus_controller.sv
// tb/tb_sequence_stimulus_controller.sv - randomized bench for sequence_stimulus_controller against a timeline model
module tb_sequence_stimulus_controller;
  localparam int SC = 4;

  logic clock = 1'b0;
  logic resetnot = 1'b1;
  always #5 clock = ~clock;

  sequence_stimulus_controller_if bus();

  sequence_stimulus_controller #(.STEP_CYCLES(SC), .CNT_W(3)) dut (
    .clock(clock),
    .resetnot(resetnot),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] m_pat;
  int          m_len;
  logic        zv [0:127];
  logic [4:0]  hold_bidx, hold_mc;

  // packed as {w_out, step, bit_index, match_count, busy, done}
  function automatic logic [13:0] pack(logic w, logic st, logic [4:0] bi, logic [4:0] mc, logic bz, logic dn);
    return {w, st, bi, mc, bz, dn};
  endfunction

  function automatic logic [13:0] pack_obs();
    return pack(bus.w_out, bus.step, bus.bit_index, bus.match_count, bus.busy, bus.done);
  endfunction

  function automatic logic [4:0] model_mc(int n);
    int c = 0;
    for (int k = 1; k <= m_len; k++)
      if (SC * k + 1 <= n && zv[SC * k + 1]) c++;
    return 5'(c);
  endfunction

  // expected outputs n edges after the accepting edge
  function automatic logic [13:0] model(int n);
    int bi;
    bi = n / SC;
    if (bi > m_len - 1) bi = m_len - 1;
    if (n <= SC * m_len)
      return pack(m_pat[bi], ((n + 1) % SC) == 0, 5'(bi), model_mc(n), 1'b1, 1'b0);
    return pack(1'b0, 1'b0, 5'(m_len - 1), model_mc(n), 1'b0, 1'b1);
  endfunction

  task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk($sformatf("%s idle %0d", tag, i), pack_obs(), pack(1'b0, 1'b0, hold_bidx, hold_mc, 1'b0, 1'b0));
      bus.start   = 1'b0;
      bus.abort   = 1'($urandom);
      bus.pattern = 16'($urandom);
      bus.length  = 5'($urandom);
      bus.z_in    = 1'($urandom);
      @(posedge clock); #1;
    end
    bus.abort = 1'b0;
  endtask

  task automatic do_run(input logic [15:0] pat, input logic [4:0] len, input bit rand_z,
                        input int abort_at, input int reset_at, input bit hold);
    logic [13:0] e;
    m_pat = pat;
    m_len = (len == 5'd0) ? 16 : int'(len);
    for (int c = 0; c <= SC * m_len + 2; c++)
      zv[c] = rand_z ? 1'($urandom) : ((c > SC) ? pat[(c - 1) / SC - 1] : 1'b0);
    bus.pattern = pat;
    bus.length  = len;
    bus.start   = 1'b1;
    bus.abort   = 1'b0;
    bus.z_in    = zv[0];
    @(posedge clock); #1;
    for (int n = 0; n <= SC * m_len + 2; n++) begin
      chk($sformatf("run len=%0d n=%0d", m_len, n), pack_obs(), model(n));
      if (hold && n == SC * m_len + 1) begin
        hold_bidx = 5'(m_len - 1);
        hold_mc   = model_mc(n);
        return;
      end
      if (n == reset_at) begin
        resetnot = 1'b0;
        #2;
        hold_bidx = '0;
        hold_mc   = '0;
        chk("async reset", pack_obs(), 14'd0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        resetnot  = 1'b1;
        @(posedge clock); #1;
        idle_check("after reset", 2);
        return;
      end
      if (n == abort_at) begin
        e = model(n);
        hold_bidx = e[11:7];
        hold_mc   = e[6:2];
        bus.abort = 1'b1;
        bus.start = 1'($urandom);
        bus.z_in  = 1'b1;
        @(posedge clock); #1;
        bus.abort = 1'b0;
        idle_check("abort", 6);
        return;
      end
      bus.start   = hold ? 1'b1 : ((n < SC * m_len) ? (($urandom % 4) == 0) : 1'b0);
      bus.pattern = 16'($urandom);
      bus.length  = 5'($urandom);
      bus.z_in    = zv[n + 1];
      @(posedge clock); #1;
    end
    hold_bidx = 5'(m_len - 1);
    hold_mc   = model_mc(SC * m_len + 2);
  endtask

  initial begin
    bus.start   = 1'b1;
    bus.abort   = 1'b0;
    bus.pattern = 16'($urandom);
    bus.length  = 5'($urandom);
    bus.z_in    = 1'b1;
    resetnot    = 1'b0;
    #3;
    chk("reset immediate", pack_obs(), 14'd0);
    #20;
    chk("reset held", pack_obs(), 14'd0);
    @(negedge clock);
    bus.start = 1'b0;
    resetnot  = 1'b1;
    hold_bidx = '0;
    hold_mc   = '0;
    @(posedge clock); #1;
    idle_check("post reset", 4);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start+abort in idle", pack_obs(), 14'd0);

    do_run(16'h000D, 5'd4, 1'b0, -1, -1, 1'b0);
    chk("basic final", pack_obs(), pack(1'b0, 1'b0, 5'd3, 5'd3, 1'b0, 1'b1));

    do_run(16'hFFFF, 5'd0, 1'b0, -1, -1, 1'b0);
    chk("len0 final", pack_obs(), pack(1'b0, 1'b0, 5'd15, 5'd16, 1'b0, 1'b1));

    do_run(16'h0003, 5'd8, 1'b0, 9, -1, 1'b0);
    chk("abort final", pack_obs(), pack(1'b0, 1'b0, 5'd2, 5'd2, 1'b0, 1'b0));

    do_run(16'hA5C3, 5'd5, 1'b0, -1, 6, 1'b0);
    do_run(16'h1234, 5'd7, 1'b0, -1, -1, 1'b1);
    do_run(16'hBEEF, 5'd3, 1'b1, -1, -1, 1'b0);

    for (int r = 0; r < 6; r++)
      do_run(16'($urandom), 5'($urandom), 1'b1, -1, -1, 1'($urandom));
    do_run(16'($urandom), 5'($urandom_range(1, 16)), 1'b1, int'($urandom_range(1, 3 * SC)), -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
